// File: rtl/pb_keyfifo.sv
// pb_keyfifo: pushbutton front end.
// Synchronizes and debounces the raw button vector, turns each new press into
// a 5-bit button index, and queues the indices in a small FIFO with a
// valid/ready handshake so downstream logic sees one event per press.
module pb_keyfifo #(
    parameter int WIDTH    = 20,
    parameter int DEBOUNCE = 3,
    parameter int DEPTH    = 4
) (
    input  logic                         hz100,
    input  logic                         reset,
    input  logic [WIDTH-1:0]             pb,
    input  logic                         ready,
    output logic                         valid,
    output logic [4:0]                   code,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         any,
    output logic                         overflow
);

    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int NW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DB_C    = CW'(DEBOUNCE);
    localparam logic [NW-1:0] DEPTH_C = NW'(DEPTH);

    // Index of the lowest set bit; only meaningful when v is non-zero.
    function automatic logic [4:0] f_lowest_idx(input logic [WIDTH-1:0] v);
        logic [4:0] idx;
        idx = 5'd0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = 5'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_last;
    logic [WIDTH-1:0] r_stable;
    logic [CW-1:0]    r_cnt;

    logic [WIDTH-1:0] w_last_next;
    logic [WIDTH-1:0] w_stable_next;
    logic [CW-1:0]    w_cnt_next;
    logic [WIDTH-1:0] w_rise;

    logic [4:0]       r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [NW-1:0]    r_count;
    logic             r_overflow;

    logic             w_valid;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic             w_wr_en;
    logic             w_drop;
    logic [4:0]       w_push_code;
    logic [NW-1:0]    w_count_next;

    // Two-stage synchronizer for the asynchronous button levels.
    always_ff @(posedge hz100 or negedge reset) begin
        if (!reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= pb;
            r_sync2 <= r_sync1;
        end
    end

    // Whole-vector debounce: stable only updates once s has matched DEBOUNCE edges in a row.
    always_comb begin
        w_last_next   = r_last;
        w_cnt_next    = r_cnt;
        w_stable_next = r_stable;
        if (r_sync2 != r_last) begin
            w_last_next = r_sync2;
            w_cnt_next  = CW'(1);
            if (DB_C == CW'(1)) begin
                w_stable_next = r_sync2;
            end else begin
                w_stable_next = r_stable;
            end
        end else if (r_cnt < DB_C) begin
            w_cnt_next = r_cnt + CW'(1);
            if (w_cnt_next == DB_C) begin
                w_stable_next = r_sync2;
            end else begin
                w_stable_next = r_stable;
            end
        end else begin
            w_stable_next = r_sync2;
        end
    end

    // Debounce state registers.
    always_ff @(posedge hz100 or negedge reset) begin
        if (!reset) begin
            r_last   <= '0;
            r_cnt    <= '0;
            r_stable <= '0;
        end else begin
            r_last   <= w_last_next;
            r_cnt    <= w_cnt_next;
            r_stable <= w_stable_next;
        end
    end

    // Press detect and FIFO control: only the lowest newly-pressed button is queued.
    always_comb begin
        w_rise       = w_stable_next & ~r_stable;
        w_push       = (w_rise != '0);
        w_push_code  = f_lowest_idx(w_rise);
        w_valid      = (r_count != '0);
        w_full       = (r_count == DEPTH_C);
        w_pop        = w_valid & ready;
        w_wr_en      = w_push & (~w_full | w_pop);
        w_drop       = w_push & w_full & ~w_pop;
        w_count_next = r_count;
        case ({w_wr_en, w_pop})
            2'b10:   w_count_next = r_count + NW'(1);
            2'b01:   w_count_next = r_count - NW'(1);
            default: w_count_next = r_count;
        endcase
    end

    // FIFO storage, pointers, occupancy and sticky overflow flag.
    always_ff @(posedge hz100 or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 5'd0;
            end
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_mem[r_wr_ptr] <= w_push_code;
                r_wr_ptr        <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count <= w_count_next;
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Outputs decoded from registers only; code reads as zero while the FIFO is empty.
    always_comb begin
        valid    = w_valid;
        count    = r_count;
        any      = |r_stable;
        overflow = r_overflow;
        if (w_valid) begin
            code = r_mem[r_rd_ptr];
        end else begin
            code = 5'd0;
        end
    end

endmodule

// File: tb/tb_pb_keyfifo.sv
// Directed self-checking bench for pb_keyfifo (default parameters).
module tb_pb_keyfifo;

    logic        hz100;
    logic        reset;
    logic [19:0] pb;
    logic        ready;
    logic        valid;
    logic [4:0]  code;
    logic [2:0]  count;
    logic        any;
    logic        overflow;

    int n_checks = 0;
    int n_fail   = 0;

    pb_keyfifo #(.WIDTH(20), .DEBOUNCE(3), .DEPTH(4)) dut (
        .hz100    (hz100),
        .reset    (reset),
        .pb       (pb),
        .ready    (ready),
        .valid    (valid),
        .code     (code),
        .count    (count),
        .any      (any),
        .overflow (overflow)
    );

    initial hz100 = 1'b0;
    always #5 hz100 = ~hz100;

    // Advance one rising edge and land 1 time unit after it.
    task automatic tick();
        @(posedge hz100);
        #1;
    endtask

    task automatic hold_pb(input logic [19:0] v, input int n);
        pb = v;
        repeat (n) tick();
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        pb    = 20'd0;
        ready = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        repeat (6) tick();
    endtask

    task automatic test_reset();
        hold_pb(20'd1 << 1, 6);
        hold_pb(20'd0, 6);
        hold_pb(20'd1 << 2, 6);
        n_checks++;
        if (count !== 3'd2) begin n_fail++; $display("FAIL reset_prefill count got %0d want 2", count); end
        pb = 20'd1 << 9;
        #3;
        reset = 1'b0;
        #1;
        n_checks++;
        if ({valid, code, count, any, overflow} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_async outputs got v=%0d c=%0d n=%0d a=%0d o=%0d want all 0",
                     valid, code, count, any, overflow);
        end
        @(posedge hz100);
        #1;
        reset = 1'b1;
        repeat (4) tick();
        n_checks++;
        if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_early valid got %0d want 0", valid); end
        tick();
        n_checks++;
        if (valid !== 1'b1 || code !== 5'd9) begin
            n_fail++; $display("FAIL reset_held_press valid=%0d code=%0d want 1/9", valid, code);
        end
        hold_pb(20'd0, 6);
        ready = 1'b1; tick(); ready = 1'b0;
    endtask

    task automatic test_single_press();
        pb = 20'd1 << 5;
        repeat (4) tick();
        n_checks++;
        if (valid !== 1'b0 || any !== 1'b0) begin
            n_fail++; $display("FAIL single_early valid=%0d any=%0d want 0/0", valid, any);
        end
        tick();
        n_checks++;
        if (valid !== 1'b1 || any !== 1'b1 || code !== 5'd5 || count !== 3'd1) begin
            n_fail++; $display("FAIL single_press v=%0d a=%0d code=%0d n=%0d want 1/1/5/1", valid, any, code, count);
        end
        repeat (5) tick();
        n_checks++;
        if (count !== 3'd1) begin n_fail++; $display("FAIL single_hold count got %0d want 1", count); end
        pb = 20'd0;
        repeat (4) tick();
        n_checks++;
        if (any !== 1'b1) begin n_fail++; $display("FAIL release_early any got %0d want 1", any); end
        tick();
        n_checks++;
        if (any !== 1'b0 || count !== 3'd1) begin
            n_fail++; $display("FAIL release any=%0d count=%0d want 0/1", any, count);
        end
        ready = 1'b1; tick(); ready = 1'b0;
        n_checks++;
        if (valid !== 1'b0 || code !== 5'd0 || count !== 3'd0) begin
            n_fail++; $display("FAIL pop_to_empty v=%0d code=%0d n=%0d want 0/0/0", valid, code, count);
        end
    endtask

    task automatic test_bounce();
        for (int i = 0; i < 7; i++) begin
            pb = (i % 2 == 0) ? (20'd1 << 3) : 20'd0;
            tick();
        end
        repeat (3) tick();
        n_checks++;
        if (valid !== 1'b0) begin n_fail++; $display("FAIL bounce_early valid got %0d want 0", valid); end
        tick();
        n_checks++;
        if (valid !== 1'b1 || code !== 5'd3) begin
            n_fail++; $display("FAIL bounce_press valid=%0d code=%0d want 1/3", valid, code);
        end
        hold_pb(20'd0, 6);
        n_checks++;
        if (count !== 3'd1) begin n_fail++; $display("FAIL bounce_single count got %0d want 1", count); end
        ready = 1'b1; tick(); ready = 1'b0;
        pb = 20'd1 << 8;
        for (int i = 0; i < 10; i++) begin
            if (i == 2) pb = 20'd0;
            tick();
            n_checks++;
            if (any !== 1'b0) begin n_fail++; $display("FAIL glitch_any cycle %0d got %0d want 0", i, any); end
        end
        n_checks++;
        if (valid !== 1'b0) begin n_fail++; $display("FAIL glitch_entry valid got %0d want 0", valid); end
    endtask

    task automatic test_simultaneous();
        hold_pb((20'd1 << 7) | (20'd1 << 12), 5);
        n_checks++;
        if (valid !== 1'b1 || code !== 5'd7 || count !== 3'd1 || overflow !== 1'b0) begin
            n_fail++; $display("FAIL simul_press v=%0d code=%0d n=%0d ovf=%0d want 1/7/1/0", valid, code, count, overflow);
        end
        hold_pb(20'd1 << 12, 6);
        n_checks++;
        if (count !== 3'd1 || any !== 1'b1) begin
            n_fail++; $display("FAIL simul_partial_release count=%0d any=%0d want 1/1", count, any);
        end
        hold_pb(20'd0, 6);
        ready = 1'b1; tick(); ready = 1'b0;
    endtask

    task automatic test_overflow_order();
        logic [4:0] btn [5];
        logic [4:0] exp_codes [4];
        btn       = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd6};
        exp_codes = '{5'd1, 5'd2, 5'd3, 5'd4};
        for (int i = 0; i < 5; i++) begin
            hold_pb(20'd1 << btn[i], 5);
            hold_pb(20'd0, 5);
            if (i == 3) begin
                n_checks++;
                if (count !== 3'd4 || overflow !== 1'b0) begin
                    n_fail++; $display("FAIL fill count=%0d ovf=%0d want 4/0", count, overflow);
                end
            end
        end
        n_checks++;
        if (count !== 3'd4 || overflow !== 1'b1) begin
            n_fail++; $display("FAIL overflow count=%0d ovf=%0d want 4/1", count, overflow);
        end
        ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (valid !== 1'b1 || code !== exp_codes[i]) begin
                n_fail++; $display("FAIL order pop %0d valid=%0d code=%0d want 1/%0d", i, valid, code, exp_codes[i]);
            end
            tick();
        end
        ready = 1'b0;
        n_checks++;
        if (valid !== 1'b0 || code !== 5'd0 || overflow !== 1'b1) begin
            n_fail++; $display("FAIL drained v=%0d code=%0d ovf=%0d want 0/0/1", valid, code, overflow);
        end
    endtask

    task automatic test_full_push_pop();
        logic [4:0] btn [4];
        logic [4:0] exp_codes [4];
        btn       = '{5'd10, 5'd11, 5'd12, 5'd13};
        exp_codes = '{5'd11, 5'd12, 5'd13, 5'd19};
        for (int i = 0; i < 4; i++) begin
            hold_pb(20'd1 << btn[i], 5);
            hold_pb(20'd0, 5);
        end
        n_checks++;
        if (count !== 3'd4 || overflow !== 1'b0) begin
            n_fail++; $display("FAIL full_prefill count=%0d ovf=%0d want 4/0", count, overflow);
        end
        hold_pb(20'd1 << 19, 4);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        n_checks++;
        if (count !== 3'd4 || overflow !== 1'b0 || code !== 5'd11) begin
            n_fail++; $display("FAIL full_pushpop count=%0d ovf=%0d code=%0d want 4/0/11", count, overflow, code);
        end
        ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (valid !== 1'b1 || code !== exp_codes[i]) begin
                n_fail++; $display("FAIL full_order pop %0d valid=%0d code=%0d want 1/%0d", i, valid, code, exp_codes[i]);
            end
            tick();
        end
        ready = 1'b0;
        n_checks++;
        if (valid !== 1'b0 || count !== 3'd0) begin
            n_fail++; $display("FAIL full_drained valid=%0d count=%0d want 0/0", valid, count);
        end
    endtask

    initial begin
        reset = 1'b0;
        pb    = 20'd0;
        ready = 1'b0;
        #2;
        n_checks++;
        if ({valid, code, count, any, overflow} !== 11'd0) begin
            n_fail++; $display("FAIL initial_reset outputs not all zero (v=%0d c=%0d n=%0d)", valid, code, count);
        end
        apply_reset();
        test_reset();
        test_single_press();
        test_bounce();
        test_simultaneous();
        test_overflow_order();
        apply_reset();
        test_full_push_pop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pb_keyfifo.md
# pb_keyfifo

Pushbutton front end that sits directly upstream of the lab top-level logic. It synchronizes and debounces the raw `pb` button vector and detects new presses. Each press is encoded to a button index, and indices are queued in a small FIFO with a valid/ready handshake, so downstream logic sees one clean event per physical press instead of a bouncing level vector.

## Interface
- `WIDTH`, 20: number of button inputs; WIDTH ≤ 32.
- `DEBOUNCE`, 3: consecutive identical samples required before the debounced vector updates; ≥ 1.
- `DEPTH`, 4: FIFO entries; power of two, ≥ 2.
- `hz100`  in  1  system clock (100 Hz); all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `pb`  in  WIDTH  raw, asynchronous, bouncing button levels (1 = pressed).
- `ready`  in  1  consumer accepts head entry this cycle.
- `valid`  out  1  FIFO not empty.
- `code`  out  5  button index of head entry; 0 when `valid`=0.
- `count`  out  $clog2(DEPTH+1)  current FIFO occupancy.
- `any`  out  1  OR of the debounced vector.
- `overflow`  out  1  sticky; set when a press is dropped because the FIFO is full.

## Operation
- Synchronizer: two flop stages per bit. `s` is the second-stage output.
- Debounce is on the whole vector:
  - `last` holds the previous `s`; `cnt` counts repeats.
  - If `s`≠`last`: `last`←`s`, `cnt`←1.
  - Else if `cnt`<`DEBOUNCE`: `cnt` increments.
  - `stable`←`s` at the edge where `s` has matched for `DEBOUNCE` consecutive edges, including that edge. That is the edge where `cnt` reaches `DEBOUNCE` or `s`=`last` with `cnt`=`DEBOUNCE`.
  - With `DEBOUNCE`=1, `stable` follows `s` with one edge of delay.
- Press detect: `rise` = next-`stable` & ~`stable`, computed at the update edge.
  - If `rise`≠0, push the index of the lowest set bit of `rise`.
  - Other bits rising in the same update are discarded. They do not set `overflow`.
  - Releases generate no events.
- FIFO:
  - Circular buffer with read and write pointers plus an occupancy counter.
  - pop = `valid` & `ready`.
  - Push when not full: enqueue.
  - Push when full, no pop: drop the push and set `overflow`.
  - Push when full with pop: both occur; `count` is unchanged and `overflow` is unaffected.
  - Push when empty: `valid` rises after that edge, with `code` = pushed index.
  - Pop when empty: ignored.
  - Pointers wrap modulo `DEPTH`.
- `overflow` clears only on reset.
- `code` is 5 bits, index zero-extended.

## Timing
- Reset (asynchronous, `reset`=0) clears all state:
  - Sync flops, `last`, `stable`, `cnt`=0, pointers, and FIFO storage are cleared.
  - Outputs `valid`=0, `code`=0, `count`=0, `any`=0, `overflow`=0 immediately, without waiting for a clock edge.
- Reset mid-operation discards queued entries and any in-progress debounce.
- A button held through reset deassertion is reported as a new press once debounced, because `stable` restarts at 0.
- Press latency: let edge k be the first edge at which `pb` carries the new value, held steady.
  - `s` changes after edge k+1.
  - `stable`, `any`, and the push take effect at edge k+1+`DEBOUNCE`. With defaults this is edge k+4.
  - `valid` and `code` follow at that edge if the FIFO was empty.
- Any change of `s` before `DEBOUNCE` matches restarts the count. Glitches shorter than `DEBOUNCE` samples at `s` never reach `stable`.
- Pop takes effect at the edge where `valid`&`ready`=1. `code` shows the next entry, or 0 if empty, after that edge.
- Outputs are registered or decoded from registers only, with no combinational path from `pb` or `ready`.

## Test plan
- Reset: assert `reset`=0 mid-stream with 2 entries queued → all outputs 0 without a clock edge. Release with `pb`=1<<9 held → `valid`=1, `code`=9 exactly 2+`DEBOUNCE` edges later.
- Single press: `pb`←1<<5 before edge k, held 10 edges, `ready`=0 → `valid` and `any` rise after edge k+4, `code`=5, `count`=1, no further pushes. Release → `any` falls after 4 edges and `count` stays 1.
- Bounce: bit 3 toggles every edge for 6 edges then holds 1 → exactly one entry, `code`=3, 4 edges after the final toggle edge. A separate 2-edge pulse on bit 8 → no entry and `any` stays 0.
- Simultaneous: `pb` 0→(1<<7)|(1<<12) in one step → one entry `code`=7, `overflow`=0. Then drop only bit 7 and debounce → no entry.
- Overflow and order: `ready`=0, presses of buttons 1, 2, 3, 4, 6 in sequence → `count`=4 and `overflow`=1 after the 5th debounce. Then `ready`=1 → codes 1, 2, 3, 4 pop on consecutive edges, `valid`=0 after the 4th pop, `overflow` still 1.
- Full with concurrent pop/push: FIFO full, `ready`=1 on the edge a new press of button 19 debounces → `count` stays 4, `overflow`=0, and 19 emerges as the last entry.
